instr_dispatch: RTL and testbench

INSTR_DISPATCH -- requirements
Module: instr_dispatch

---
 rtl/instr_dispatch_if.sv | 34 +++
 rtl/instr_dispatch.sv | 133 +++++++++++++
 tb/tb_instr_dispatch.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_dispatch_if.sv
// Dispatcher-to-environment bundle: instruction handshake, unit start/done
// strobes, held operand fields and status outputs.
interface instr_dispatch_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        start_move;
    logic        start_add;
    logic        start_sub;
    logic        start_ldi;
    logic        done_move;
    logic        done_add;
    logic        done_sub;
    logic        done_ldi;
    logic [5:0]  ri;
    logic [5:0]  rj;
    logic        busy;
    logic        retire;
    logic        err_illegal;
    logic        err_timeout;
    logic [7:0]  retired_count;

    modport master (
        output instr, instr_valid, done_move, done_add, done_sub, done_ldi,
        input  instr_ready, start_move, start_add, start_sub, start_ldi,
               ri, rj, busy, retire, err_illegal, err_timeout, retired_count
    );

    modport slave (
        input  instr, instr_valid, done_move, done_add, done_sub, done_ldi,
        output instr_ready, start_move, start_add, start_sub, start_ldi,
               ri, rj, busy, retire, err_illegal, err_timeout, retired_count
    );
endinterface

// File: rtl/instr_dispatch.sv
// Single-issue instruction dispatcher: decodes one instruction at a time, starts
// the matching execution unit, waits for its done (bounded) and retires it.
module instr_dispatch #(
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           reset,
    instr_dispatch_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RETIRE = 2'd3
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state_reg;
    logic [3:0]  sel_reg;          // one-hot unit select: {ldi, sub, add, move}
    logic [3:0]  start_reg;
    logic [7:0]  wait_cnt_reg;
    logic [5:0]  ri_reg;
    logic [5:0]  rj_reg;
    logic        instr_ready_reg;
    logic        busy_reg;
    logic        retire_reg;
    logic        err_illegal_reg;
    logic        err_timeout_reg;
    logic [7:0]  retired_count_reg;

    logic [3:0]  sel_decode;
    logic [3:0]  done_vec;
    logic        sel_done;

    always_comb begin
        sel_decode = 4'b0000;
        case (bus.instr[15:12])
            4'b0111: sel_decode = 4'b0001;
            4'b0010: sel_decode = 4'b0010;
            4'b0011: sel_decode = 4'b0100;
            4'b0001: sel_decode = 4'b1000;
            default: sel_decode = 4'b0000;
        endcase
    end

    // Only the latched unit's done can complete the instruction.
    assign done_vec = {bus.done_ldi, bus.done_sub, bus.done_add, bus.done_move};
    assign sel_done = |(sel_reg & done_vec);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            sel_reg           <= 4'b0000;
            start_reg         <= 4'b0000;
            wait_cnt_reg      <= 8'd0;
            ri_reg            <= 6'd0;
            rj_reg            <= 6'd0;
            instr_ready_reg   <= 1'b1;
            busy_reg          <= 1'b0;
            retire_reg        <= 1'b0;
            err_illegal_reg   <= 1'b0;
            err_timeout_reg   <= 1'b0;
            retired_count_reg <= 8'd0;
        end else begin
            start_reg       <= 4'b0000;
            retire_reg      <= 1'b0;
            err_illegal_reg <= 1'b0;
            err_timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.instr_valid) begin
                        if (|sel_decode) begin
                            sel_reg         <= sel_decode;
                            start_reg       <= sel_decode;
                            ri_reg          <= bus.instr[11:6];
                            rj_reg          <= bus.instr[5:0];
                            state_reg       <= ISSUE;
                            instr_ready_reg <= 1'b0;
                            busy_reg        <= 1'b1;
                        end else begin
                            err_illegal_reg <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt_reg <= 8'd0;
                    state_reg    <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the final allowed cycle still retires.
                    if (sel_done) begin
                        state_reg         <= RETIRE;
                        retire_reg        <= 1'b1;
                        retired_count_reg <= retired_count_reg + 8'd1;
                        wait_cnt_reg      <= 8'd0;
                    end else if (wait_cnt_reg == LAST_WAIT) begin
                        state_reg       <= IDLE;
                        err_timeout_reg <= 1'b1;
                        instr_ready_reg <= 1'b1;
                        busy_reg        <= 1'b0;
                        wait_cnt_reg    <= 8'd0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                RETIRE: begin
                    state_reg       <= IDLE;
                    instr_ready_reg <= 1'b1;
                    busy_reg        <= 1'b0;
                end
                default: begin
                    state_reg       <= IDLE;
                    instr_ready_reg <= 1'b1;
                    busy_reg        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.instr_ready   = instr_ready_reg;
    assign bus.start_move    = start_reg[0];
    assign bus.start_add     = start_reg[1];
    assign bus.start_sub     = start_reg[2];
    assign bus.start_ldi     = start_reg[3];
    assign bus.ri            = ri_reg;
    assign bus.rj            = rj_reg;
    assign bus.busy          = busy_reg;
    assign bus.retire        = retire_reg;
    assign bus.err_illegal   = err_illegal_reg;
    assign bus.err_timeout   = err_timeout_reg;
    assign bus.retired_count = retired_count_reg;
endmodule

// File: tb/tb_instr_dispatch.sv
// Directed bench for instr_dispatch: move, illegal, timeout, foreign dones,
// retired_count wrap under back-to-back issue, and mid-instruction reset.
module tb_instr_dispatch;
    logic clk;
    logic reset;

    instr_dispatch_if bus ();

    instr_dispatch #(.TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Pulse/handshake monitors, sampled on the active edge.
    int start_seen  = 0;
    int retire_seen = 0;
    int err_seen    = 0;
    int accept_seen = 0;

    always @(posedge clk) begin
        if (bus.start_move | bus.start_add | bus.start_sub | bus.start_ldi) start_seen++;
        if (bus.retire) retire_seen++;
        if (bus.err_illegal | bus.err_timeout) err_seen++;
        if (bus.instr_valid && bus.instr_ready) accept_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] starts();
        return {bus.start_ldi, bus.start_sub, bus.start_add, bus.start_move};
    endfunction

    int base_start;
    int base_retire;
    int base_accept;
    int base_err;
    logic [7:0] exp_cnt;
    logic wrapped;

    initial begin
        reset           = 1'b1;
        bus.instr       = 16'h0000;
        bus.instr_valid = 1'b0;
        bus.done_move   = 1'b0;
        bus.done_add    = 1'b0;
        bus.done_sub    = 1'b0;
        bus.done_ldi    = 1'b0;
        tick();
        tick();
        check("rst_ready", bus.instr_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_starts", starts(), 0);
        check("rst_ri", bus.ri, 0);
        check("rst_rj", bus.rj, 0);
        check("rst_count", bus.retired_count, 0);
        check("rst_pulses", {bus.retire, bus.err_illegal, bus.err_timeout}, 0);
        reset = 1'b0;
        tick();

        // move Ri=7 Rj=2, done_move two cycles after the start pulse
        bus.instr = 16'h71C2; bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        check("mv_start", starts(), 4'b0001);
        check("mv_busy", bus.busy, 1);
        check("mv_ready", bus.instr_ready, 0);
        check("mv_ri", bus.ri, 7);
        check("mv_rj", bus.rj, 2);
        tick();
        check("mv_start_off", starts(), 0);
        check("mv_w1_retire", bus.retire, 0);
        tick();
        bus.done_move = 1'b1;
        check("mv_w2_retire", bus.retire, 0);
        check("mv_w2_ri", bus.ri, 7);
        tick();
        bus.done_move = 1'b0;
        check("mv_retire", bus.retire, 1);
        check("mv_count", bus.retired_count, 1);
        check("mv_ret_rj", bus.rj, 2);
        tick();
        check("mv_idle_retire", bus.retire, 0);
        check("mv_idle_busy", bus.busy, 0);
        check("mv_idle_ready", bus.instr_ready, 1);
        check("mv_idle_ri", bus.ri, 7);
        check("mv_nstart", start_seen, 1);
        check("mv_nretire", retire_seen, 1);
        $display("txn move ri=%0d rj=%0d count=%0d", bus.ri, bus.rj, bus.retired_count);

        // illegal opcode
        bus.instr = 16'hF000; bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        check("ill_err", bus.err_illegal, 1);
        check("ill_ready", bus.instr_ready, 1);
        check("ill_busy", bus.busy, 0);
        check("ill_starts", starts(), 0);
        check("ill_count", bus.retired_count, 1);
        check("ill_ri", bus.ri, 7);
        tick();
        check("ill_err_off", bus.err_illegal, 0);
        check("ill_nstart", start_seen, 1);
        $display("txn illegal instr=f000");

        // add with no done: abort after 15 WAIT cycles
        bus.instr = 16'h20C5; bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        check("to_start", starts(), 4'b0010);
        check("to_ri", bus.ri, 3);
        check("to_rj", bus.rj, 5);
        tick();
        for (int i = 1; i <= 15; i++) begin
            check($sformatf("to_w%0d_err", i), bus.err_timeout, 0);
            check($sformatf("to_w%0d_busy", i), bus.busy, 1);
            tick();
        end
        check("to_err", bus.err_timeout, 1);
        check("to_busy", bus.busy, 0);
        check("to_ready", bus.instr_ready, 1);
        check("to_count", bus.retired_count, 1);
        check("to_nretire", retire_seen, 1);
        tick();
        check("to_err_off", bus.err_timeout, 0);
        $display("txn add timeout");

        // sub: done on start cycle and foreign dones ignored
        bus.instr = 16'h3294; bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        bus.done_sub = 1'b1;
        check("sub_start", starts(), 4'b0100);
        tick();
        bus.done_sub = 1'b0; bus.done_move = 1'b1;
        check("sub_w1_retire", bus.retire, 0);
        tick();
        bus.done_move = 1'b0; bus.done_add = 1'b1;
        check("sub_w2_retire", bus.retire, 0);
        tick();
        bus.done_add = 1'b0;
        check("sub_w3_retire", bus.retire, 0);
        tick();
        bus.done_sub = 1'b1;
        check("sub_w4_retire", bus.retire, 0);
        check("sub_w4_busy", bus.busy, 1);
        tick();
        bus.done_sub = 1'b0;
        check("sub_retire", bus.retire, 1);
        check("sub_count", bus.retired_count, 2);
        check("sub_ri", bus.ri, 10);
        check("sub_rj", bus.rj, 20);
        tick();
        check("sub_idle", bus.busy, 0);
        $display("txn sub ri=%0d rj=%0d count=%0d", bus.ri, bus.rj, bus.retired_count);

        // 256 back-to-back ldi with valid and done_ldi held high
        base_start  = start_seen;
        base_retire = retire_seen;
        base_accept = accept_seen;
        exp_cnt     = 8'd2;
        wrapped     = 1'b0;
        bus.done_ldi = 1'b1;
        bus.instr = 16'h1042; bus.instr_valid = 1'b1;
        for (int c = 0; c < 1024; c++) begin
            tick();
            if (bus.retire) begin
                exp_cnt = exp_cnt + 8'd1;
                if (exp_cnt == 8'd0) wrapped = 1'b1;
                check("ldi_count", bus.retired_count, exp_cnt);
            end
        end
        bus.instr_valid = 1'b0;
        bus.done_ldi = 1'b0;
        check("ldi_naccept", accept_seen - base_accept, 256);
        check("ldi_nstart", start_seen - base_start, 256);
        check("ldi_nretire", retire_seen - base_retire, 256);
        check("ldi_wrapped", wrapped, 1);
        check("ldi_final", bus.retired_count, 2);
        check("ldi_ri", bus.ri, 1);
        tick();
        check("ldi_idle", bus.busy, 0);
        $display("txn ldi x256 count=%0d", bus.retired_count);

        // reset while waiting
        bus.instr = 16'h7149; bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        check("rw_ri", bus.ri, 5);
        tick();
        tick();
        base_retire = retire_seen;
        base_err    = err_seen;
        #2 reset = 1'b1;
        #1;
        check("rw_busy", bus.busy, 0);
        check("rw_ready", bus.instr_ready, 1);
        check("rw_ri0", bus.ri, 0);
        check("rw_rj0", bus.rj, 0);
        check("rw_count", bus.retired_count, 0);
        check("rw_starts", starts(), 0);
        tick();
        check("rw_pulses", {bus.retire, bus.err_illegal, bus.err_timeout}, 0);
        reset = 1'b0;
        tick();
        check("rw_nretire", retire_seen - base_retire, 0);
        check("rw_nerr", err_seen - base_err, 0);
        check("rw_idle", bus.busy, 0);

        // minimum-latency move after reset
        bus.instr = 16'h71C2; bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        check("pr_start", starts(), 4'b0001);
        check("pr_ri", bus.ri, 7);
        tick();
        bus.done_move = 1'b1;
        tick();
        bus.done_move = 1'b0;
        check("pr_retire", bus.retire, 1);
        check("pr_count", bus.retired_count, 1);
        tick();
        check("pr_idle", bus.busy, 0);
        $display("txn move after reset count=%0d", bus.retired_count);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
